// File: rtl/crc_check_param_if.sv
// Rx-side CRC checker bus: per-bit strobes in from the unstuffer, CRC state and verdict out.
interface crc_check_param_if #(
  parameter int CRC_WIDTH = 16,
  parameter int CNT_W     = 11
);
  logic                 start;
  logic                 shift_enable;
  logic                 serial_in;
  logic                 shift_stop;
  logic                 eop;
  logic                 abort;
  logic [CRC_WIDTH-1:0] crc_value;
  logic                 busy;
  logic                 result_valid;
  logic                 crc_ok;
  logic [CNT_W-1:0]     bit_count;
  logic [7:0]           err_count;

  modport master (
    output start, shift_enable, serial_in, shift_stop, eop, abort,
    input  crc_value, busy, result_valid, crc_ok, bit_count, err_count
  );

  modport slave (
    input  start, shift_enable, serial_in, shift_stop, eop, abort,
    output crc_value, busy, result_valid, crc_ok, bit_count, err_count
  );
endinterface

// File: rtl/crc_check_param.sv
// Parametrised serial CRC checker: one packet FSM (IDLE/ACCUM/REPORT) that shifts
// unstuffed bits through a CRC register and emits a one-cycle verdict after EOP.
module crc_check_param #(
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY      = 16'h8005,
  parameter logic [CRC_WIDTH-1:0] INIT      = '1,
  parameter logic [CRC_WIDTH-1:0] RESIDUE   = 16'h800D,
  parameter int                   MIN_BITS  = 16,
  parameter int                   CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  crc_check_param_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BITS);

  state_t               state;
  logic [CRC_WIDTH-1:0] crc;
  logic [CNT_W-1:0]     bit_cnt;
  logic [7:0]           err_cnt;
  logic                 busy;
  logic                 result_valid;
  logic                 crc_ok;

  logic [CRC_WIDTH-1:0] crc_shifted;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 verdict;

  // NOTE: every always_comb output is assigned unconditionally, so no latch can form.
  always_comb begin
    crc_shifted = {crc[CRC_WIDTH-2:0], bus.serial_in} ^ (crc[CRC_WIDTH-1] ? POLY : '0);
    cnt_inc     = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;
    verdict     = (crc == RESIDUE) && (bit_cnt >= MIN_CNT);
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state        <= IDLE;
      crc          <= INIT;
      bit_cnt      <= '0;
      err_cnt      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      crc_ok       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      crc_ok       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            crc     <= INIT;
            bit_cnt <= '0;
          end
        end
        ACCUM: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.start) begin
            crc     <= INIT;
            bit_cnt <= '0;
          end else if (bus.eop) begin
            // The register already holds the final remainder; the EOP-cycle strobe is dropped.
            state        <= REPORT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            crc_ok       <= verdict;
            if (!verdict && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (bus.shift_enable && !bus.shift_stop) begin
            crc     <= crc_shifted;
            bit_cnt <= cnt_inc;
          end
        end
        REPORT: begin
          if (bus.start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            crc     <= INIT;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.crc_value    = crc;
  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.crc_ok       = crc_ok;
  assign bus.bit_count    = bit_cnt;
  assign bus.err_count    = err_cnt;

endmodule

// File: tb/tb_crc_check_param.sv
// Self-checking bench: a CRC16 and a CRC5 checker share one stimulus stream and are
// compared against a polynomial-division reference model of the received bit sequence.
module tb_crc_check_param;

  localparam logic [31:0] P16 = 32'h8005, I16 = 32'hFFFF, R16 = 32'h800D;
  localparam logic [31:0] P5  = 32'h05,   I5  = 32'h1F,   R5  = 32'h0C;
  localparam int MIN_BITS = 16;
  localparam int CNT_MAX  = 2047;

  logic clk = 1'b0;
  logic sync_rst;
  always #5 clk = ~clk;

  crc_check_param_if #(.CRC_WIDTH(16), .CNT_W(11)) b16 ();
  crc_check_param_if #(.CRC_WIDTH(5),  .CNT_W(11)) b5 ();

  assign b5.start        = b16.start;
  assign b5.shift_enable = b16.shift_enable;
  assign b5.serial_in    = b16.serial_in;
  assign b5.shift_stop   = b16.shift_stop;
  assign b5.eop          = b16.eop;
  assign b5.abort        = b16.abort;

  crc_check_param dut16 (.clk(clk), .sync_rst(sync_rst), .bus(b16));

  crc_check_param #(
    .CRC_WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C), .MIN_BITS(16), .CNT_W(11)
  ) dut5 (.clk(clk), .sync_rst(sync_rst), .bus(b5));

  int errors;
  int checks;
  int err16;
  int err5;
  bit pkt[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of v modulo x^w + poly, by long division over GF(2).
  function automatic logic [31:0] poly_mod(input logic [159:0] v, input int w, input logic [31:0] poly);
    logic [159:0] g;
    g = 160'(poly) | (160'd1 << w);
    for (int d = 159; d >= w; d--)
      if (v[d]) v = v ^ (g << (d - w));
    return v[31:0];
  endfunction

  // init * x^n + M(x), first received bit being the highest-order coefficient.
  function automatic logic [159:0] pkt_value(input logic [31:0] init);
    logic [159:0] v;
    v = 160'(init);
    foreach (pkt[i]) v = {v[158:0], pkt[i]};
    return v;
  endfunction

  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly, input logic [31:0] init);
    return poly_mod(pkt_value(init), w, poly);
  endfunction

  task automatic drive(input bit s, input bit se, input bit sin, input bit ss, input bit e, input bit a);
    b16.start        = s;
    b16.shift_enable = se;
    b16.serial_in    = sin;
    b16.shift_stop   = ss;
    b16.eop          = e;
    b16.abort        = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Sends pkt with random idle cycles and stuffed (ignored) strobes in between.
  task automatic send_pkt();
    int gap;
    foreach (pkt[i]) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++)
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0);
      drive(0, 1, pkt[i], 0, 0, 0);
    end
  endtask

  // Called right after the EOP edge: verdict visible now, counters updated model-side.
  task automatic expect_verdict();
    int  n;
    bit  ok16;
    bit  ok5;
    n    = pkt.size();
    ok16 = (model_crc(16, P16, I16) == R16) && (n >= MIN_BITS);
    ok5  = (model_crc(5, P5, I5) == R5) && (n >= MIN_BITS);
    check("rv16", 64'(b16.result_valid), 64'(1));
    check("ok16", 64'(b16.crc_ok), 64'(ok16));
    check("rv5", 64'(b5.result_valid), 64'(1));
    check("ok5", 64'(b5.crc_ok), 64'(ok5));
    if (!ok16 && err16 < 255) err16++;
    if (!ok5 && err5 < 255) err5++;
  endtask

  task automatic run_pkt(input int plen, input bit use5, input bit flip);
    int          w;
    int          idx;
    int          n;
    logic [31:0] poly, init, res, c;
    drive(1, 0, 0, 0, 0, 0);
    pkt.delete();
    check("pkt_busy", 64'(b16.busy), 64'(1));
    check("pkt_init16", 64'(b16.crc_value), 64'(I16));
    check("pkt_init5", 64'(b5.crc_value), 64'(I5));
    repeat (plen) pkt.push_back(1'($urandom_range(0, 1)));
    w    = use5 ? 5 : 16;
    poly = use5 ? P5 : P16;
    init = use5 ? I5 : I16;
    res  = use5 ? R5 : R16;
    c    = res ^ poly_mod(pkt_value(init) << w, w, poly);
    for (int b = w - 1; b >= 0; b--) pkt.push_back(c[b]);
    if (flip) begin
      idx = int'($urandom_range(0, pkt.size() - 1));
      pkt[idx] = ~pkt[idx];
    end
    n = pkt.size();
    send_pkt();
    check("pre_eop_crc16", 64'(b16.crc_value), 64'(model_crc(16, P16, I16)));
    check("pre_eop_crc5", 64'(b5.crc_value), 64'(model_crc(5, P5, I5)));
    check("pre_eop_cnt", 64'(b16.bit_count), 64'(n));
    drive(0, 1, 1'($urandom_range(0, 1)), 0, 1, 0);
    expect_verdict();
    idle();
    check("rv16_drop", 64'(b16.result_valid), 64'(0));
    check("rv5_drop", 64'(b5.result_valid), 64'(0));
    check("err16", 64'(b16.err_count), 64'(err16));
    check("err5", 64'(b5.err_count), 64'(err5));
    repeat (2) drive(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
    check("idle_hold_crc", 64'(b16.crc_value), 64'(model_crc(16, P16, I16)));
    check("idle_hold_cnt", 64'(b16.bit_count), 64'(n));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    errors = 0;
    checks = 0;
    err16  = 0;
    err5   = 0;

    sync_rst = 1'b1;
    idle();
    idle();
    sync_rst = 1'b0;
    check("rst_crc16", 64'(b16.crc_value), 64'(I16));
    check("rst_crc5", 64'(b5.crc_value), 64'(I5));
    check("rst_cnt", 64'(b16.bit_count), 64'(0));
    check("rst_err", 64'(b16.err_count), 64'(0));
    check("rst_rv", 64'(b16.result_valid), 64'(0));
    check("rst_ok", 64'(b16.crc_ok), 64'(0));
    check("rst_busy", 64'(b16.busy), 64'(0));

    // Single bit after start
    drive(1, 0, 0, 0, 0, 0);
    pkt.delete();
    check("start_busy", 64'(b16.busy), 64'(1));
    drive(0, 1, 0, 0, 0, 0);
    pkt.push_back(1'b0);
    check("one_bit_crc16", 64'(b16.crc_value), 64'(16'h7FFB));
    check("one_bit_model16", 64'(b16.crc_value), 64'(model_crc(16, P16, I16)));
    check("one_bit_crc5", 64'(b5.crc_value), 64'(model_crc(5, P5, I5)));
    check("one_bit_cnt", 64'(b16.bit_count), 64'(1));

    // Restart mid-packet, then stuffed and absent strobes
    drive(1, 0, 0, 0, 0, 0);
    pkt.delete();
    check("restart_crc", 64'(b16.crc_value), 64'(I16));
    check("restart_cnt", 64'(b16.bit_count), 64'(0));
    drive(0, 1, 1, 1, 0, 0);
    check("stuff_crc", 64'(b16.crc_value), 64'(I16));
    check("stuff_cnt", 64'(b16.bit_count), 64'(0));
    drive(0, 0, 1, 0, 0, 0);
    check("nostrobe_crc", 64'(b16.crc_value), 64'(I16));

    // Short packet
    drive(0, 0, 0, 0, 1, 0);
    expect_verdict();
    check("short_busy", 64'(b16.busy), 64'(0));
    idle();
    check("short_rv_drop", 64'(b16.result_valid), 64'(0));
    check("short_err", 64'(b16.err_count), 64'(err16));

    // Reset mid-packet
    drive(1, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
    sync_rst = 1'b1;
    drive(0, 1, 1, 0, 1, 0);
    sync_rst = 1'b0;
    err16 = 0;
    err5  = 0;
    check("midrst_busy", 64'(b16.busy), 64'(0));
    check("midrst_crc", 64'(b16.crc_value), 64'(16'hFFFF));
    check("midrst_err", 64'(b16.err_count), 64'(0));
    check("midrst_cnt", 64'(b16.bit_count), 64'(0));
    check("midrst_rv", 64'(b16.result_valid), 64'(0));
    drive(0, 1, 1, 0, 0, 0);
    check("idle_ignore_crc", 64'(b16.crc_value), 64'(16'hFFFF));
    check("idle_ignore_cnt", 64'(b16.bit_count), 64'(0));

    // CRC16 packets: exact-minimum length, random good ones, corrupted ones
    run_pkt(0, 0, 0);
    repeat (3) run_pkt(int'($urandom_range(8, 64)), 0, 0);
    repeat (2) run_pkt(int'($urandom_range(8, 64)), 0, 1);

    // CRC5 tokens: good, one bit short of minimum, corrupted
    run_pkt(11, 1, 0);
    run_pkt(10, 1, 0);
    run_pkt(11, 1, 1);

    // Abort beats a simultaneous EOP and strobe; no verdict follows
    drive(1, 0, 0, 0, 0, 0);
    pkt.delete();
    repeat (12) begin
      pkt.push_back(1'($urandom_range(0, 1)));
      drive(0, 1, pkt[pkt.size() - 1], 0, 0, 0);
    end
    drive(0, 1, 1, 0, 1, 1);
    check("abort_busy", 64'(b16.busy), 64'(0));
    check("abort_rv", 64'(b16.result_valid), 64'(0));
    check("abort_crc", 64'(b16.crc_value), 64'(model_crc(16, P16, I16)));
    check("abort_cnt", 64'(b16.bit_count), 64'(12));
    seen = 0;
    repeat (3) begin
      idle();
      if (b16.result_valid || b5.result_valid) seen++;
    end
    check("abort_no_verdict", 64'(seen), 64'(0));
    check("abort_err", 64'(b16.err_count), 64'(err16));

    // Start during REPORT: verdict still emitted, new packet begins
    drive(1, 0, 0, 0, 0, 0);
    pkt.delete();
    repeat (20) begin
      pkt.push_back(1'($urandom_range(0, 1)));
      drive(0, 1, pkt[pkt.size() - 1], 0, 0, 0);
    end
    drive(0, 0, 0, 0, 1, 0);
    expect_verdict();
    drive(1, 0, 0, 0, 0, 0);
    check("rpt_start_busy", 64'(b16.busy), 64'(1));
    check("rpt_start_crc", 64'(b16.crc_value), 64'(I16));
    check("rpt_start_cnt", 64'(b16.bit_count), 64'(0));
    check("rpt_start_rv", 64'(b16.result_valid), 64'(0));
    drive(0, 0, 0, 0, 0, 1);
    check("rpt_start_err16", 64'(b16.err_count), 64'(err16));
    check("rpt_start_err5", 64'(b5.err_count), 64'(err5));

    // Error counter saturation
    repeat (260) begin
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0);
      idle();
    end
    err16 = (err16 + 260 > 255) ? 255 : err16 + 260;
    err5  = (err5 + 260 > 255) ? 255 : err5 + 260;
    check("err16_sat", 64'(b16.err_count), 64'(err16));
    check("err5_sat", 64'(b5.err_count), 64'(err5));

    // Bit counter saturation
    drive(1, 0, 0, 0, 0, 0);
    repeat (CNT_MAX + 3) drive(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
    check("cnt16_sat", 64'(b16.bit_count), 64'(CNT_MAX));
    check("cnt5_sat", 64'(b5.bit_count), 64'(CNT_MAX));
    drive(0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
